regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised integer register file for the 5-stage pipeline, successor to the single-write 32x32 file.
//  Adds NRD read ports, write-to-read bypass, asynchronous clear and a per-register pending-write scoreboard.
//  The scoreboard is a set of saturating counters: decode reserves a destination, writeback releases it.
//  Sits between ID (reads/issue) and WB (write/release); drives operand-ready flags to hazard/stall logic.
// PARAMETERS
//  XLEN   32  data width of each register
//  NREG   32  number of architectural registers; index 0 is hardwired zero
//  AW     5   register index width, must equal $clog2(NREG)
//  NRD    2   number of read ports
//  CNTW   2   pending-counter width; max 2**CNTW-1 outstanding writes per register
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  ra         in   NRD*AW     read addresses, port i at [i*AW +: AW]
//  rd         out  NRD*XLEN   read data, port i at [i*XLEN +: XLEN]
//  rd_rdy     out  NRD        port i operand valid (no write pending, or pending write resolved this cycle)
//  we         in   1          writeback enable
//  wa         in   AW         writeback address
//  wd         in   XLEN       writeback data
//  iss_v      in   1          issue: reserve destination iss_rd
//  iss_rd     in   AW         destination being reserved
//  iss_full   out  1          pending counter of iss_rd is at max; issue must stall
//  flush      in   1          synchronous: clear all pending counters (pipeline squash)
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers <= 0, all counters <= 0; hence rd=0, rd_rdy=all 1, iss_full=0.
//  Read: combinational. rd[i] = 0 if ra[i]==0; else wd if (we && wa==ra[i] && wa!=0) (bypass); else regfile[ra[i]].
//  rd_rdy[i] = (ra[i]==0) | (cnt[ra[i]]==0) | (cnt[ra[i]]==1 && we && wa==ra[i]).
//  Write: on posedge, if we && wa!=0, regfile[wa] <= wd. Writes to index 0 have no effect.
//  Counter update per register r at posedge (r!=0 only; cnt[0] is constant 0):
//   inc = iss_v && iss_rd==r && !iss_full;  dec = we && wa==r && cnt[r]!=0.
//   inc&dec -> unchanged; inc -> +1; dec -> -1; dec at 0 is ignored (stray writeback, no underflow).
//  iss_full = iss_v && iss_rd!=0 && cnt[iss_rd]==max && !(we && wa==iss_rd). Issue while full is dropped.
//  flush=1: all counters <= 0 at next edge; has priority over inc/dec; register writes still performed.
//  Issue to register 0: no counter change, iss_full=0.
//  Latency: reads 0 cycles; write visible on rd next cycle, same cycle via bypass; counter change visible next cycle.
//  Reset asserted mid-operation: state cleared immediately, independent of clk; no partial update on release edge.
// STRUCTURE
//  Shared package rf_pkg: XLEN, NREG, AW constants; zero-register index localparam.
//  One sub-module: rf_pend_cnt (one saturating up/down counter with flush, instantiated NREG-1 times via generate).
//  Storage array, bypass muxes and ready logic live in the top; read ports via generate loop over NRD.
// TESTING
//  1 reset: rst_n=0 mid-run after writes -> every ra reads 0, rd_rdy=2'b11, iss_full=0 without a clock edge.
//  2 bypass: we=1 wa=5 wd=32'hDEADBEEF, ra0=5 same cycle -> rd0=32'hDEADBEEF; next cycle we=0 -> still DEADBEEF.
//  3 x0: we=1 wa=0 wd=32'hFFFFFFFF; iss_v iss_rd=0 -> ra0=0 reads 0, rd_rdy[0]=1, iss_full=0.
//  4 scoreboard: issue rd=7 twice, ra1=7 -> rd_rdy[1]=0; one writeback to 7 -> still 0; second writeback same cycle -> 1.
//  5 saturation: CNTW=2, issue rd=3 three times -> iss_full=1 on 4th; 4th dropped; simultaneous we wa=3 -> iss_full=0, cnt stays 3.
//  6 flush: counters of r4,r9 nonzero, flush=1 with iss_v rd=4 -> next cycle rd_rdy for 4 and 9 = 1; stray we wa=9 -> no underflow.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared sizing constants for the scoreboarded register file
package rf_pkg;
  localparam int RF_XLEN     = 32;
  localparam int RF_NREG     = 32;
  localparam int RF_AW       = 5;
  localparam int RF_NRD      = 2;
  localparam int RF_CNTW     = 2;
  localparam int RF_ZERO_IDX = 0;
endpackage

// File: rtl/rf_pend_cnt.sv
// rtl/rf_pend_cnt.sv - per-register pending-write counter with flush
module rf_pend_cnt #(
  parameter int CNTW = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_inc,
  input  logic            i_dec_req,
  input  logic            i_flush,
  output logic [CNTW-1:0] o_cnt
);
  logic [CNTW-1:0] r_cnt;
  logic            w_dec;

  // A writeback with nothing pending is a stray and must not wrap the count.
  assign w_dec = i_dec_req && (r_cnt != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else if (i_inc && !w_dec) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_dec && !i_inc) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write bypass and pending-write scoreboard
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int AW   = RF_AW,
  parameter int NRD  = RF_NRD,
  parameter int CNTW = RF_CNTW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NRD*AW-1:0] i_ra,
  output logic [NRD*XLEN-1:0] o_rd,
  output logic [NRD-1:0]    o_rd_rdy,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wa,
  input  logic [XLEN-1:0]   i_wd,
  input  logic              i_iss_v,
  input  logic [AW-1:0]     i_iss_rd,
  output logic              o_iss_full,
  input  logic              i_flush
);
  localparam logic [AW-1:0] ZERO = AW'(RF_ZERO_IDX);

  logic [XLEN-1:0] r_regs [NREG];
  logic [CNTW-1:0] w_cnt  [NREG];
  logic            w_wr_ok;

  assign w_wr_ok = i_we && (i_wa != ZERO);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        r_regs[k] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // A full destination may still accept an issue if its writeback lands this same cycle.
  assign o_iss_full = i_iss_v && (i_iss_rd != ZERO) && (w_cnt[i_iss_rd] == '1)
                      && !(i_we && (i_wa == i_iss_rd));

  assign w_cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic w_inc;
    assign w_inc = i_iss_v && (i_iss_rd == AW'(r)) && !o_iss_full;
    rf_pend_cnt #(.CNTW(CNTW)) u_cnt (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_inc     (w_inc),
      .i_dec_req (i_we && (i_wa == AW'(r))),
      .i_flush   (i_flush),
      .o_cnt     (w_cnt[r])
    );
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_byp;
    assign w_ra  = i_ra[i*AW +: AW];
    assign w_byp = w_wr_ok && (i_wa == w_ra);
    assign o_rd[i*XLEN +: XLEN] = (w_ra == ZERO) ? '0 :
                                  w_byp          ? i_wd : r_regs[w_ra];
    assign o_rd_rdy[i] = (w_ra == ZERO) || (w_cnt[w_ra] == '0) ||
                         ((w_cnt[w_ra] == CNTW'(1)) && i_we && (i_wa == w_ra));
  end
endmodule
